nes_pad_poll_scheduler: RTL and testbench

//  Sequences polling of both NES controller ports, which share one latch line and have separate clock lines.
//  - Arbitrates periodic (frame-rate) and on-demand host poll requests into a single poll engine.
//  - Serialises 9 bits per port, including a presence bit, and publishes both pads' button bytes atomically.
//  - Sits between the pad connector pins and the core's $4016/$4017 input logic.

---
 rtl/nes_pad_poll_scheduler_pkg.sv | 25 ++
 rtl/nes_pad_poll_scheduler_if.sv | 24 ++
 rtl/nes_pad_poll_scheduler_tick.sv | 25 ++
 rtl/nes_pad_poll_scheduler.sv | 157 +++++++++++++++
 tb/tb_nes_pad_poll_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/nes_pad_poll_scheduler_pkg.sv
// rtl/nes_pad_poll_scheduler_pkg.sv - shared states, button indices and timing defaults for the pad poller
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    HOLD,
    LOW,
    DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEF_TICK_CYCLES = 162;
  localparam int DEF_POLL_CYCLES = 450000;
  localparam int DEF_NUM_BITS    = 9;

endpackage

// File: rtl/nes_pad_poll_scheduler_if.sv
// rtl/nes_pad_poll_scheduler_if.sv - host request/result and pad connector signals of the poller
interface nes_pad_poll_scheduler_if;
  logic       i_enable;
  logic       i_req;
  logic       o_latch;
  logic [1:0] o_clk;
  logic [1:0] i_data;
  logic [7:0] o_pad0;
  logic [7:0] o_pad1;
  logic [1:0] o_present;
  logic       o_valid;
  logic       o_busy;
  logic       o_drop;

  modport slave (
    input  i_enable, i_req, i_data,
    output o_latch, o_clk, o_pad0, o_pad1, o_present, o_valid, o_busy, o_drop
  );

  modport master (
    output i_enable, i_req, i_data,
    input  o_latch, o_clk, o_pad0, o_pad1, o_present, o_valid, o_busy, o_drop
  );
endinterface

// File: rtl/nes_pad_poll_scheduler_tick.sv
// rtl/nes_pad_poll_scheduler_tick.sv - 6 us tick divider with synchronous clear
import nes_pad_pkg::*;

module nes_pad_tick #(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);
  localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] cnt;

  // Count 0..TICK_CYCLES-1; clear restarts the tick phase at the start of a poll
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign o_tick = (cnt == LAST);
endmodule

// File: rtl/nes_pad_poll_scheduler.sv
// rtl/nes_pad_poll_scheduler.sv - arbitrates periodic/host polls and serialises both NES pad ports
import nes_pad_pkg::*;

module nes_pad_poll_scheduler #(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES,
  parameter int NUM_BITS    = DEF_NUM_BITS
) (
  input logic                       i_clk,
  input logic                       i_rst,
  nes_pad_poll_scheduler_if.slave   pads
);
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_POLL = PW'(POLL_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(NUM_BITS - 1);

  state_t              state, state_next;
  logic [3:0]          bit_idx, bit_next;
  logic [1:0]          sync_q1, sync_q2;
  logic [PW-1:0]       poll_cnt;
  logic                periodic, req_any, accept, pending, drop_q;
  logic                tick, sample, latch, valid_q;
  logic [1:0]          pclk, present_q;
  logic [NUM_BITS-2:0] sr0, sr1;
  logic [NUM_BITS-1:0] sr0_next, sr1_next;
  logic [7:0]          pad0_q, pad1_q;

  // Two-flop synchroniser per port for the asynchronous pad data lines
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pads.i_data;
      sync_q2 <= sync_q1;
    end
  end

  assign periodic = pads.i_enable && (poll_cnt == LAST_POLL);

  // Frame-rate counter; parked at zero while periodic polling is disabled
  always_ff @(posedge i_clk) begin
    if (i_rst || !pads.i_enable) poll_cnt <= '0;
    else if (periodic)           poll_cnt <= '0;
    else                         poll_cnt <= poll_cnt + 1'b1;
  end

  assign req_any = pads.i_req | periodic;
  assign accept  = (state == IDLE) && pending;

  // One-deep request slot; a request landing on the accept cycle refills it instead of dropping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= req_any && pending && !accept;
      if (accept)       pending <= req_any;
      else if (req_any) pending <= 1'b1;
    end
  end

  nes_pad_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (accept),
    .o_tick  (tick)
  );

  // Poll state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_next;
    end
  end

  // Poll sequencing; bit_idx counts latch ticks in LATCH and shifted bits afterwards
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    latch      = 1'b0;
    pclk       = 2'b11;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_next = LATCH;
          bit_next   = '0;
        end
      end
      LATCH: begin
        latch = 1'b1;
        if (tick) begin
          if (bit_idx == 4'd1) begin
            state_next = HOLD;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 4'd1;
          end
        end
      end
      HOLD: begin
        sample = tick;
        if (tick) state_next = (bit_idx == LAST_BIT) ? DONE : LOW;
      end
      LOW: begin
        pclk = 2'b00;
        if (tick) begin
          state_next = HOLD;
          bit_next   = bit_idx + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sr0_next = {~sync_q2[0], sr0};
  assign sr1_next = {~sync_q2[1], sr1};

  // Shift in button bits LSB first and publish both pads together on the final bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr0       <= '0;
      sr1       <= '0;
      pad0_q    <= '0;
      pad1_q    <= '0;
      present_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (sample) begin
        sr0 <= sr0_next[NUM_BITS-1:1];
        sr1 <= sr1_next[NUM_BITS-1:1];
        if (bit_idx == LAST_BIT) begin
          present_q <= {sr1_next[NUM_BITS-1], sr0_next[NUM_BITS-1]};
          pad0_q    <= sr0_next[NUM_BITS-1] ? sr0_next[7:0] : 8'h00;
          pad1_q    <= sr1_next[NUM_BITS-1] ? sr1_next[7:0] : 8'h00;
          valid_q   <= 1'b1;
        end
      end
    end
  end

  assign pads.o_latch   = latch;
  assign pads.o_clk     = pclk;
  assign pads.o_pad0    = pad0_q;
  assign pads.o_pad1    = pad1_q;
  assign pads.o_present = present_q;
  assign pads.o_valid   = valid_q;
  assign pads.o_busy    = (state != IDLE);
  assign pads.o_drop    = drop_q;
endmodule

// File: tb/tb_nes_pad_poll_scheduler.sv
// tb/tb_nes_pad_poll_scheduler.sv - directed bench with a 4021 shift register model on each port
import nes_pad_pkg::*;

module tb_nes_pad_poll_scheduler;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  nes_pad_poll_scheduler_if bus ();

  nes_pad_poll_scheduler #(.TICK_CYCLES(4), .POLL_CYCLES(200), .NUM_BITS(9)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .pads  (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  // 4021 models: parallel load while latch is high, shift on each rising data clock
  logic [7:0] btn0 = 8'h00;
  logic [7:0] btn1 = 8'h00;
  logic       empty1 = 1'b0;
  logic [7:0] q0 = 8'hFF;
  logic [7:0] q1 = 8'hFF;
  wire        pclk0 = bus.o_clk[0];
  wire        pclk1 = bus.o_clk[1];
  wire        plat  = bus.o_latch;

  always @(posedge plat or posedge pclk0) begin
    if (plat) q0 <= ~btn0;
    else      q0 <= {1'b0, q0[7:1]};
  end

  always @(posedge plat or posedge pclk1) begin
    if (plat) q1 <= ~btn1;
    else      q1 <= {1'b0, q1[7:1]};
  end

  assign bus.i_data = {empty1 ? 1'b1 : q1[0], q0[0]};

  // Activity counters sampled on the falling edge
  int         valid_cnt = 0;
  int         drop_cnt  = 0;
  int         latch_cyc = 0;
  int         falls0    = 0;
  int         falls1    = 0;
  int         low0_cyc  = 0;
  logic [1:0] prev_clk  = 2'b11;

  always @(negedge i_clk) begin
    if (bus.o_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (bus.o_drop === 1'b1)  drop_cnt  <= drop_cnt + 1;
    if (bus.o_latch === 1'b1) latch_cyc <= latch_cyc + 1;
    if (prev_clk[0] && bus.o_clk[0] === 1'b0) falls0 <= falls0 + 1;
    if (prev_clk[1] && bus.o_clk[1] === 1'b0) falls1 <= falls1 + 1;
    if (bus.o_clk[0] === 1'b0) low0_cyc <= low0_cyc + 1;
    prev_clk <= bus.o_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_req();
    bus.i_req = 1'b1;
    step();
    bus.i_req = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.o_valid !== 1'b1 && n < limit);
    if (bus.o_valid !== 1'b1) check({tag, "_timeout"}, 32'(bus.o_valid), 32'd1);
  endtask

  int n, v0, d0, l0, f0, f1, lc0;

  initial begin
    bus.i_enable = 1'b0;
    bus.i_req    = 1'b0;
    repeat (3) step();
    check("rst_latch",   32'(bus.o_latch),   32'd0);
    check("rst_clk",     32'(bus.o_clk),     32'd3);
    check("rst_pad0",    32'(bus.o_pad0),    32'd0);
    check("rst_pad1",    32'(bus.o_pad1),    32'd0);
    check("rst_present", 32'(bus.o_present), 32'd0);
    check("rst_valid",   32'(bus.o_valid),   32'd0);
    check("rst_busy",    32'(bus.o_busy),    32'd0);
    i_rst = 1'b0;
    step();

    // Basic poll: pad0 A+Start, pad1 nothing
    btn0 = 8'h00;
    btn0[BTN_A] = 1'b1;
    btn0[BTN_START] = 1'b1;
    btn1 = 8'h00;
    l0 = latch_cyc; f0 = falls0; f1 = falls1; lc0 = low0_cyc;
    pulse_req();
    check("accept_busy", 32'(bus.o_busy), 32'd0);
    wait_valid("basic", 200, n);
    check("basic_latency", 32'(n),            32'd77);
    check("basic_pad0",    32'(bus.o_pad0),   32'h09);
    check("basic_pad1",    32'(bus.o_pad1),   32'h00);
    check("basic_present", 32'(bus.o_present), 32'd3);
    check("basic_latch_cycles", 32'(latch_cyc - l0), 32'd8);
    check("basic_clk0_pulses",  32'(falls0 - f0),    32'd8);
    check("basic_clk1_pulses",  32'(falls1 - f1),    32'd8);
    check("basic_clk0_low",     32'(low0_cyc - lc0), 32'd32);
    step();
    check("basic_valid_pulse", 32'(bus.o_valid), 32'd0);
    check("basic_idle",        32'(bus.o_busy),  32'd0);

    // Empty port 1, pad0 presses B
    empty1 = 1'b1;
    btn0 = 8'h02;
    pulse_req();
    wait_valid("empty", 200, n);
    check("empty_present", 32'(bus.o_present), 32'd1);
    check("empty_pad1",    32'(bus.o_pad1),    32'h00);
    check("empty_pad0",    32'(bus.o_pad0),    32'h02);
    empty1 = 1'b0;
    step();

    // One extra request mid-poll: served right after DONE, nothing dropped
    btn0 = 8'h81;
    btn1 = 8'h40;
    d0 = drop_cnt;
    pulse_req();
    repeat (20) step();
    pulse_req();
    wait_valid("arb1_first", 200, n);
    check("arb1_pad0", 32'(bus.o_pad0), 32'h81);
    check("arb1_pad1", 32'(bus.o_pad1), 32'h40);
    btn0 = 8'h10;
    wait_valid("arb1_second", 200, n);
    check("arb1_gap",  32'(n),              32'd78);
    check("arb1_pad0b", 32'(bus.o_pad0),    32'h10);
    check("arb1_drop", 32'(drop_cnt - d0),  32'd0);
    step();

    // Two extra requests mid-poll: one dropped, one extra poll
    v0 = valid_cnt;
    d0 = drop_cnt;
    pulse_req();
    repeat (20) step();
    pulse_req();
    repeat (5) step();
    pulse_req();
    repeat (300) step();
    check("arb2_drop",  32'(drop_cnt - d0),  32'd1);
    check("arb2_polls", 32'(valid_cnt - v0), 32'd2);

    // Periodic polling
    d0 = drop_cnt;
    bus.i_enable = 1'b1;
    wait_valid("per_first", 400, n);
    wait_valid("per_second", 400, n);
    check("per_gap1", 32'(n), 32'd200);
    wait_valid("per_third", 400, n);
    check("per_gap2", 32'(n), 32'd200);
    check("per_drop", 32'(drop_cnt - d0), 32'd0);
    bus.i_enable = 1'b0;
    repeat (100) step();
    v0 = valid_cnt;
    repeat (500) step();
    check("per_disabled", 32'(valid_cnt - v0), 32'd0);

    // Reset during LOW(4)
    v0 = valid_cnt;
    pulse_req();
    repeat (46) step();
    check("low4_clk",  32'(bus.o_clk),  32'd0);
    check("low4_busy", 32'(bus.o_busy), 32'd1);
    i_rst = 1'b1;
    step();
    check("mid_rst_latch",   32'(bus.o_latch),   32'd0);
    check("mid_rst_clk",     32'(bus.o_clk),     32'd3);
    check("mid_rst_busy",    32'(bus.o_busy),    32'd0);
    check("mid_rst_valid",   32'(bus.o_valid),   32'd0);
    check("mid_rst_pad0",    32'(bus.o_pad0),    32'd0);
    check("mid_rst_present", 32'(bus.o_present), 32'd0);
    i_rst = 1'b0;
    repeat (150) step();
    check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("mid_rst_idle",     32'(bus.o_busy),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
